// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter giving two requesters a shared ALU with an IDLE/EXEC/DONE handshake
module alu #(
  parameter int DSIZE = 16
) (
  input  logic [2:0]       op,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic [DSIZE-1:0] imm,
  output logic [DSIZE-1:0] y
);
  always_comb
    y = op == 3'd0 ? a + b :
        op == 3'd1 ? a - b :
        op == 3'd2 ? a & b :
        op == 3'd3 ? a ^ b :
        op == 3'd4 ? a << imm :
        op == 3'd5 ? a >> imm :
        op == 3'd6 ? DSIZE'(a <= b) :
        op == 3'd7 ? a * b : '0;
endmodule

module alu_arbiter #(
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [DSIZE-1:0] r0_a,
  input  logic [DSIZE-1:0] r0_b,
  input  logic [DSIZE-1:0] r0_imm,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [DSIZE-1:0] r1_a,
  input  logic [DSIZE-1:0] r1_b,
  input  logic [DSIZE-1:0] r1_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [DSIZE-1:0] rsp_data,
  output logic             busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic             last_grant;
  logic [2:0]       op_q;
  logic [DSIZE-1:0] a_q, b_q, imm_q, alu_y;
  logic             id_q;
  logic             idle;
  assign idle     = state == IDLE && !rst;
  assign r0_ready = idle && r0_valid && (!r1_valid || last_grant);
  assign r1_ready = idle && r1_valid && (!r0_valid || !last_grant);
  assign busy     = state != IDLE && !rst;
  alu #(.DSIZE(DSIZE)) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .imm(imm_q),
    .y  (alu_y)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      id_q       <= 1'b0;
    end else if (state == IDLE) begin
      if (r0_ready || r1_ready) begin
        op_q       <= r1_ready ? r1_op : r0_op;
        a_q        <= r1_ready ? r1_a : r0_a;
        b_q        <= r1_ready ? r1_b : r0_b;
        imm_q      <= r1_ready ? r1_imm : r0_imm;
        id_q       <= r1_ready;
        last_grant <= r1_ready;
        state      <= EXEC;
      end
    end else if (state == EXEC) begin
      rsp_data  <= alu_y;
      rsp_id    <= id_q;
      rsp_valid <= 1'b1;
      state     <= DONE;
    end else if (state == DONE) begin
      if (rsp_ready) begin
        rsp_valid <= 1'b0;
        state     <= IDLE;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural arbitration/ALU model and randomized traffic
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [2:0]  r0_op, r1_op;
  logic [15:0] r0_a, r0_b, r0_imm, r1_a, r1_b, r1_imm;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0] rsp_data;
  typedef struct {
    bit          id;
    logic [15:0] d;
  } rsp_t;
  rsp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          free = 1'b1;
  bit          last = 1'b1;
  int          age = 0;
  bit          hold_prev = 1'b0;
  logic        prev_id;
  logic [15:0] prev_data;

  alu_arbiter #(.DSIZE(16)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_imm(r0_imm),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_imm(r1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input longint a, input longint b, input longint imm);
    longint r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b + 65536;
      3'd2: r = a & b;
      3'd3: r = a ^ b;
      3'd4: r = imm >= 16 ? 0 : a * (longint'(1) << imm);
      3'd5: r = imm >= 16 ? 0 : a / (longint'(1) << imm);
      3'd6: r = a <= b ? 1 : 0;
      3'd7: r = a * b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    bit e0, e1;
    if (rst) begin
      chk("r0_ready_in_reset", r0_ready, 0);
      chk("r1_ready_in_reset", r1_ready, 0);
      chk("busy_in_reset", busy, 0);
      free = 1'b1;
      last = 1'b1;
      age = 0;
      exp_q.delete();
    end else begin
      e0 = free && r0_valid && (!r1_valid || last);
      e1 = free && r1_valid && (!r0_valid || !last);
      chk("r0_ready", r0_ready, e0);
      chk("r1_ready", r1_ready, e1);
      chk("busy", busy, !free);
      chk("rsp_valid", rsp_valid, !free && age >= 1);
      if (e0 || e1) begin
        exp_q.push_back('{id: e1, d: e1 ? ref_alu(r1_op, r1_a, r1_b, r1_imm) : ref_alu(r0_op, r0_a, r0_b, r0_imm)});
        free = 1'b0;
        age = 0;
        last = e1;
      end else if (!free) begin
        if (age >= 1 && rsp_ready) free = 1'b1;
        else if (age < 2) age++;
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (!rst && hold_prev) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, prev_data);
      chk("hold_id", rsp_id, prev_id);
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.d);
      end
    end
    hold_prev = !rst && rsp_valid && !rsp_ready;
    prev_data = rsp_data;
    prev_id = rsp_id;
  end

  task automatic req(input bit id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm);
    bit got = 1'b0;
    if (id) {r1_valid, r1_op, r1_a, r1_b, r1_imm} = {1'b1, op, a, b, imm};
    else {r0_valid, r0_op, r0_a, r0_b, r0_imm} = {1'b1, op, a, b, imm};
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? r1_ready : r0_ready;
    end
    if (!got) chk("grant_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) r1_valid = 1'b0;
    else r0_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {r0_valid, r0_op, r0_a, r0_b, r0_imm} = '0;
    {r1_valid, r1_op, r1_a, r1_b, r1_imm} = '0;
    rsp_ready = 1'b1;
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_id", rsp_id, 0);
    cycles(1);
    req(0, 3'd0, 16'd5, 16'd3, 16'd0);
    cycles(4);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    {r0_valid, r0_op, r0_a, r0_b, r0_imm} = {1'b1, 3'd1, 16'd10, 16'd4, 16'd0};
    {r1_valid, r1_op, r1_a, r1_b, r1_imm} = {1'b1, 3'd7, 16'd300, 16'd300, 16'd0};
    cycles(9);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    cycles(4);
    req(1, 3'd4, 16'h0001, 16'd0, 16'd15);
    req(1, 3'd4, 16'h0001, 16'd0, 16'd16);
    req(0, 3'd6, 16'd7, 16'd7, 16'd0);
    req(0, 3'd6, 16'd8, 16'd7, 16'd0);
    req(1, 3'd5, 16'h8000, 16'd0, 16'd15);
    cycles(3);
    rsp_ready = 1'b0;
    req(0, 3'd3, 16'h1234, 16'h00ff, 16'd0);
    {r1_valid, r1_op, r1_a, r1_b, r1_imm} = {1'b1, 3'd0, 16'hffff, 16'd2, 16'd0};
    cycles(6);
    rsp_ready = 1'b1;
    cycles(4);
    r1_valid = 1'b0;
    cycles(3);
    req(0, 3'd2, 16'hf0f0, 16'h3c3c, 16'd0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    cycles(1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    cycles(4);
    req(1, 3'd0, 16'd1, 16'd1, 16'd0);
    cycles(3);
    {r0_valid, r0_op, r0_a, r0_b} = {1'b1, 3'd0, 16'd20, 16'd22};
    r1_valid = 1'b1;
    cycles(1);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    cycles(5);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      r0_valid = $urandom_range(0, 2) != 0;
      r1_valid = $urandom_range(0, 2) != 0;
      r0_op = 3'($urandom);
      r1_op = 3'($urandom);
      r0_a = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 9));
      r1_a = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 9));
      r0_b = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 9));
      r1_b = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 9));
      r0_imm = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'($urandom_range(0, 20));
      r1_imm = $urandom_range(0, 7) == 0 ? 16'($urandom) : 16'($urandom_range(0, 20));
      rsp_ready = $urandom_range(0, 3) != 0;
      cycles(1);
    end
    rst = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rsp_ready = 1'b1;
    cycles(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
